riscv_muldiv: RTL

Parametrised, multi-cycle arithmetic unit that adds the RV32M/RV64M multiply/divide operations to the datapath. It sits beside the single-cycle ALU in the execute stage, decodes `opcode`/`funct3`/`funct7[0]` itself, and exchanges operands and results with the pipeline over valid/ready handshakes. It stalls the pipeline while busy and handles every divide corner case in hardware.

---
 rtl/riscv_muldiv.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_muldiv.sv
// ============================================================================
// riscv_muldiv -- multi-cycle RV32M/RV64M multiply/divide unit
//
// Sits beside the execute-stage ALU. It decodes opcode/funct3/funct7_0 itself
// and exchanges operands and results over valid/ready handshakes.
//   Multiply: radix-2 shift-add on operand magnitudes, XLEN iterations.
//   Divide  : restoring division on operand magnitudes, XLEN iterations.
// Sign correction and high/low half selection happen in a single FIX cycle.
// Divide-by-zero and signed overflow are resolved at accept time and go
// straight to DONE, as do non-M (illegal) operations.
//
// Configuration macro: RISCV_MULDIV_DIV_EN
//   defined   : multiply and divide/remainder supported
//   undefined : divider removed; funct3[2]=1 ops complete as illegal
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   flush     in   synchronous abort of any in-flight operation
//   in_valid  in   operation presented
//   in_ready  out  unit idle and able to accept
//   opcode    in   instruction bits [6:0]
//   funct3    in   instruction bits [14:12]
//   funct7_0  in   instruction bit 25
//   op_a      in   rs1 value
//   op_b      in   rs2 value
//   out_valid out  result available
//   out_ready in   consumer takes the result
//   result    out  product, quotient or remainder
//   illegal   out  accepted operation was not an M-extension op
// ============================================================================
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          f3_q;
    logic                neg_q;       // result (product / quotient) must be negated
    logic [XLEN-1:0]     a_mag_q;     // multiplicand magnitude
    logic [2*XLEN-1:0]   acc_q;       // mul: {product_hi, multiplier}; div: {rem, quotient}
    logic                in_ready_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;
    logic                illegal_q;
`ifdef RISCV_MULDIV_DIV_EN
    logic                neg_rem_q;   // remainder takes the dividend's sign
    logic [XLEN-1:0]     b_mag_q;     // divisor magnitude
`endif

    logic                legal_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     mul_res_s;
    logic [XLEN-1:0]     fix_res_s;

    // Decode legality and operand signedness; form operand magnitudes.
    always_comb begin
`ifdef RISCV_MULDIV_DIV_EN
        legal_s = (opcode == 7'b0110011) && funct7_0;
`else
        legal_s = (opcode == 7'b0110011) && funct7_0 && !funct3[2];
`endif
        // DIV/REM signed, DIVU/REMU unsigned; MULHSU has only rs1 signed.
        a_signed_s = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_s = funct3[2] ? ~funct3[0] : ~funct3[1];
        sign_a_s   = a_signed_s & op_a[XLEN-1];
        sign_b_s   = b_signed_s & op_b[XLEN-1];
        a_mag_s    = sign_a_s ? (ZERO - op_a) : op_a;
        b_mag_s    = sign_b_s ? (ZERO - op_b) : op_b;
    end

`ifdef RISCV_MULDIV_DIV_EN
    // Divide corner cases that bypass the iterative datapath.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = ZERO;
        if (legal_s && funct3[2] && (op_b == ZERO)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? op_a : ONES;
        end else if (legal_s && funct3[2] && !funct3[0] && (op_a == MIN) && (op_b == ONES)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? ZERO : MIN;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO;
        end
    end
`else
    assign special_s     = 1'b0;
    assign special_res_s = ZERO;
`endif

    // One shift-add or restoring-divide iteration on the accumulator.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
        step_s    = {mul_sum_s, acc_q[XLEN-1:1]};
`ifdef RISCV_MULDIV_DIV_EN
        if (f3_q[2]) begin
            step_s = div_step(acc_q, b_mag_q);
        end else begin
            step_s = {mul_sum_s, acc_q[XLEN-1:1]};
        end
`endif
    end

`ifdef RISCV_MULDIV_DIV_EN
    // Shift the next dividend bit into the partial remainder and subtract
    // the divisor when it fits. A failed trial leaves the shifted remainder
    // below the divisor, so its top bit is zero and XLEN bits suffice.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   dvs);
        logic [XLEN:0]   rem_shift;
        logic            ge;
        logic [XLEN-1:0] rem_next;
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge        = (rem_shift >= {1'b0, dvs});
        rem_next  = ge ? (rem_shift[XLEN-1:0] - dvs) : rem_shift[XLEN-1:0];
        return {rem_next, acc[XLEN-2:0], ge};
    endfunction
`endif

    // Sign correction and half selection for the FIX cycle.
    always_comb begin
        prod_s    = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
        mul_res_s = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef RISCV_MULDIV_DIV_EN
        if (f3_q[2]) begin
            if (f3_q[1]) begin
                fix_res_s = neg_rem_q ? (ZERO - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
            end else begin
                fix_res_s = neg_q ? (ZERO - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
            end
        end else begin
            fix_res_s = mul_res_s;
        end
`else
        fix_res_s = f3_q[2] ? ZERO : mul_res_s;
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            f3_q        <= 3'b000;
            neg_q       <= 1'b0;
            a_mag_q     <= ZERO;
            acc_q       <= {(2*XLEN){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= ZERO;
            illegal_q   <= 1'b0;
`ifdef RISCV_MULDIV_DIV_EN
            neg_rem_q   <= 1'b0;
            b_mag_q     <= ZERO;
`endif
        end else if (flush) begin
            // Flush beats a same-cycle accept and drops any pending result.
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        f3_q       <= funct3;
                        neg_q      <= sign_a_s ^ sign_b_s;
                        a_mag_q    <= a_mag_s;
                        in_ready_q <= 1'b0;
`ifdef RISCV_MULDIV_DIV_EN
                        neg_rem_q  <= sign_a_s;
                        b_mag_q    <= b_mag_s;
                        acc_q      <= funct3[2] ? {ZERO, a_mag_s} : {ZERO, b_mag_s};
`else
                        acc_q      <= {ZERO, b_mag_s};
`endif
                        if (!legal_s) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= ZERO;
                            illegal_q   <= 1'b1;
                        end else if (special_s) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= special_res_s;
                            illegal_q   <= 1'b0;
                        end else begin
                            state_q     <= S_BUSY;
                            cnt_q       <= CNT_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q <= step_s;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q     <= S_DONE;
                    result_q    <= fix_res_s;
                    illegal_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule
